// File: rtl/piano_voice_scheduler.sv
// piano_voice_scheduler
//   Polyphonic voice scheduler. Each accepted sample tick snapshots the eight
//   key levels and runs one frame of work:
//     SCAN  (8 cycles)  : frees voices whose key was released, then gives a
//                         free voice to each newly pressed key (lowest key first).
//     ACCUM (NV cycles) : steps the phase of every allocated voice and adds AMP
//                         to the sum when the phase MSB is set (square wave).
//     OUT   (1 cycle)   : publishes the sum on wave and pulses wave_valid.
//   A single shared phase adder is time-multiplexed across all voices.
//
// Ports
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   keys[7:0]    in   key levels, bit k = key k, 1 = pressed
//   sample_tick  in   one-cycle strobe at the audio sample rate
//   wave[7:0]    out  current output sample, held between frames
//   wave_valid   out  one-cycle pulse when wave updates
//   busy         out  high while a frame is in progress
//   voice_active out  bit v = voice v allocated
//   overrun      out  sticky; a tick arrived while busy (cleared by rst)
module piano_voice_scheduler #(
  parameter int NV       = 4,
  parameter int PW       = 16,
  parameter int BASE_INC = 1000,
  parameter int STEP_INC = 125
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    keys,
  input  logic          sample_tick,
  output logic [7:0]    wave,
  output logic          wave_valid,
  output logic          busy,
  output logic [NV-1:0] voice_active,
  output logic          overrun
);

  localparam int          VW  = (NV > 1) ? $clog2(NV) : 1;
  localparam logic [7:0]  AMP = 8'(255 / NV);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_ACCUM, S_OUT} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [2:0]      r_cnt;
  logic [7:0]      r_snap;
  logic [7:0]      r_sum;
  logic [7:0]      r_wave;
  logic            r_wave_valid;
  logic            r_overrun;
  logic [NV-1:0]   r_alloc;
  logic [2:0]      r_owner [NV];
  logic [PW-1:0]   r_phase [NV];

  logic            w_own_hit;
  logic [VW-1:0]   w_own_idx;
  logic            w_free_hit;
  logic [VW-1:0]   w_free_idx;
  logic [VW-1:0]   w_vidx;
  logic [PW-1:0]   w_new_phase;

  // Phase increment for a key index, truncated to the accumulator width.
  function automatic logic [PW-1:0] inc_of(input logic [2:0] k);
    logic [31:0] t;
    t = 32'(BASE_INC) + 32'(k) * 32'(STEP_INC);
    return t[PW-1:0];
  endfunction

  // Voice lookups for the key under scan: the voice owning it (if any) and
  // the lowest-index free voice.
  always_comb begin
    w_own_hit  = 1'b0;
    w_own_idx  = '0;
    w_free_hit = 1'b0;
    w_free_idx = '0;
    for (int v = 0; v < NV; v++) begin
      if (r_alloc[v] && (r_owner[v] == r_cnt) && !w_own_hit) begin
        w_own_hit = 1'b1;
        w_own_idx = VW'(v);
      end
    end
    for (int v = NV - 1; v >= 0; v--) begin
      if (!r_alloc[v]) begin
        w_free_hit = 1'b1;
        w_free_idx = VW'(v);
      end
    end
  end

  // Shared phase adder for the voice handled in the current ACCUM cycle.
  assign w_vidx      = r_cnt[VW-1:0];
  assign w_new_phase = r_phase[w_vidx] + inc_of(r_owner[w_vidx]);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (sample_tick) w_next = S_SCAN;
      S_SCAN:  if (r_cnt == 3'd7) w_next = S_ACCUM;
      S_ACCUM: if (r_cnt == 3'(NV - 1)) w_next = S_OUT;
      S_OUT:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt        <= '0;
      r_snap       <= '0;
      r_sum        <= '0;
      r_wave       <= '0;
      r_wave_valid <= 1'b0;
      r_overrun    <= 1'b0;
      r_alloc      <= '0;
      for (int v = 0; v < NV; v++) begin
        r_owner[v] <= '0;
        r_phase[v] <= '0;
      end
    end else begin
      r_wave_valid <= 1'b0;
      if (sample_tick && (r_state != S_IDLE)) r_overrun <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (sample_tick) begin
            r_snap <= keys;
            r_sum  <= '0;
            r_cnt  <= '0;
          end
        end
        S_SCAN: begin
          r_cnt <= r_cnt + 3'd1;
          if (!r_snap[r_cnt] && w_own_hit) begin
            r_alloc[w_own_idx] <= 1'b0;
          end else if (r_snap[r_cnt] && !w_own_hit && w_free_hit) begin
            r_alloc[w_free_idx] <= 1'b1;
            r_owner[w_free_idx] <= r_cnt;
            r_phase[w_free_idx] <= '0;
          end
        end
        S_ACCUM: begin
          r_cnt <= r_cnt + 3'd1;
          if (r_alloc[w_vidx]) begin
            r_phase[w_vidx] <= w_new_phase;
            if (w_new_phase[PW-1]) r_sum <= r_sum + AMP;
          end
        end
        S_OUT: begin
          r_wave       <= r_sum;
          r_wave_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign wave         = r_wave;
  assign wave_valid   = r_wave_valid;
  assign busy         = (r_state != S_IDLE);
  assign voice_active = r_alloc;
  assign overrun      = r_overrun;

endmodule

// File: tb/tb_piano_voice_scheduler.sv
module tb_piano_voice_scheduler;

  localparam int NV  = 4;
  localparam int AMP = 255 / NV;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    keys = 8'h00;
  logic          sample_tick = 1'b0;
  logic [7:0]    wave;
  logic          wave_valid;
  logic          busy;
  logic [NV-1:0] voice_active;
  logic          overrun;

  piano_voice_scheduler #(.NV(NV), .PW(16), .BASE_INC(1000), .STEP_INC(125)) dut (
    .clk(clk), .rst(rst), .keys(keys), .sample_tick(sample_tick),
    .wave(wave), .wave_valid(wave_valid), .busy(busy),
    .voice_active(voice_active), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  // Reference model: voice table and one-frame update computed from the rules.
  bit m_alloc [NV];
  int m_owner [NV];
  int m_phase [NV];
  int m_wave;

  function automatic void m_reset();
    for (int v = 0; v < NV; v++) begin
      m_alloc[v] = 0; m_owner[v] = 0; m_phase[v] = 0;
    end
    m_wave = 0;
  endfunction

  function automatic void m_frame(input logic [7:0] k);
    int sum;
    for (int key = 0; key < 8; key++) begin
      int owned;
      owned = -1;
      for (int v = 0; v < NV; v++)
        if (m_alloc[v] && m_owner[v] == key && owned < 0) owned = v;
      if (!k[key] && owned >= 0) begin
        m_alloc[owned] = 0;
      end else if (k[key] && owned < 0) begin
        int fr;
        fr = -1;
        for (int v = 0; v < NV; v++) if (!m_alloc[v] && fr < 0) fr = v;
        if (fr >= 0) begin
          m_alloc[fr] = 1; m_owner[fr] = key; m_phase[fr] = 0;
        end
      end
    end
    sum = 0;
    for (int v = 0; v < NV; v++) begin
      if (m_alloc[v]) begin
        m_phase[v] = (m_phase[v] + 1000 + m_owner[v] * 125) % 65536;
        if (m_phase[v] >= 32768) sum += AMP;
      end
    end
    m_wave = sum;
  endfunction

  function automatic logic [NV-1:0] m_active();
    logic [NV-1:0] a;
    for (int v = 0; v < NV; v++) a[v] = m_alloc[v];
    return a;
  endfunction

  // Runs ncyc cycles starting at an edge where a tick is driven (offset 0).
  // Optional second tick at offset t2, reset pulse at offset rst_at, and a
  // keys change to midk at offset 3. Reports wave_valid pulses seen.
  task automatic run_window(input int t2, input int rst_at, input int ncyc,
                            input logic [7:0] midk,
                            output int pulses, output int lat, output logic [7:0] w);
    pulses = 0; lat = -1; w = 8'h00;
    for (int c = 0; c < ncyc; c++) begin
      sample_tick = (c == 0) || (c == t2);
      rst = (c == rst_at);
      if (c == 3) keys = midk;
      @(posedge clk);
      #1;
      sample_tick = 1'b0;
      rst = 1'b0;
      if (wave_valid) begin
        pulses++;
        if (lat < 0) lat = c;
        w = wave;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_reset();
  endtask

  task automatic frame(input string tag, input logic [7:0] k, input logic [7:0] midk);
    int p, l;
    logic [7:0] w;
    keys = k;
    run_window(-1, -1, 20, midk, p, l, w);
    m_frame(k);
    chk({tag, "_pulses"}, p, 1);
    chk({tag, "_lat"}, l, 13);
    chk({tag, "_wave"}, w, m_wave);
    chk({tag, "_active"}, voice_active, m_active());
    chk({tag, "_overrun"}, overrun, 0);
  endtask

  initial begin
    int p, l;
    logic [7:0] w;

    // Reset held with ticks and keys active.
    rst = 1'b1; sample_tick = 1'b1; keys = 8'hFF;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_wave", wave, 0);
    chk("rst_valid", wave_valid, 0);
    chk("rst_active", voice_active, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    sample_tick = 1'b0; rst = 1'b0; keys = 8'h00;
    @(posedge clk); #1;
    chk("rst_tick_nostart", busy, 0);
    m_reset();

    // Single key 0 for 70 samples.
    for (int s = 1; s <= 70; s++) begin
      frame($sformatf("key0_s%0d", s), 8'h01, 8'h01);
      if (s == 32) chk("key0_s32_const", wave, 0);
      if (s == 33) chk("key0_s33_const", wave, 63);
      if (s == 65) chk("key0_s65_const", wave, 63);
      if (s == 66) chk("key0_s66_const", wave, 0);
    end
    chk("key0_active_const", voice_active, 4'b0001);

    // Oversubscription and reassignment.
    do_reset();
    frame("over1", 8'b0001_1111, 8'b0001_1111);
    chk("over1_all", voice_active, 4'b1111);
    frame("over2", 8'b0001_1101, 8'b0001_1101);
    for (int s = 0; s < 30; s++) frame($sformatf("over3_%0d", s), 8'b0001_1101, 8'b0001_1101);

    // Release everything.
    frame("release", 8'h00, 8'h00);
    chk("release_active", voice_active, 0);
    chk("release_wave", wave, 0);

    // Random key patterns, keys also changed mid-frame.
    for (int s = 0; s < 60; s++) begin
      logic [7:0] k;
      k = 8'($urandom);
      frame($sformatf("rand_%0d", s), k, 8'($urandom));
    end

    // Overrun: second tick during SCAN.
    do_reset();
    keys = 8'h03;
    run_window(5, -1, 22, 8'h03, p, l, w);
    m_frame(8'h03);
    chk("ovr5_pulses", p, 1);
    chk("ovr5_lat", l, 13);
    chk("ovr5_flag", overrun, 1);
    chk("ovr5_wave", w, m_wave);

    // Overrun: tick in the OUT cycle.
    do_reset();
    run_window(13, -1, 22, 8'h03, p, l, w);
    chk("ovr13_pulses", p, 1);
    chk("ovr13_flag", overrun, 1);

    // Tick right after OUT is accepted.
    do_reset();
    run_window(14, -1, 30, 8'h03, p, l, w);
    m_frame(8'h03);
    m_frame(8'h03);
    chk("ovr14_pulses", p, 2);
    chk("ovr14_flag", overrun, 0);
    chk("ovr14_wave", w, m_wave);

    // Mid-frame reset after some voices exist.
    do_reset();
    frame("pre_mid", 8'h5A, 8'h5A);
    frame("pre_mid2", 8'h5A, 8'h5A);
    run_window(-1, 6, 20, 8'h5A, p, l, w);
    m_reset();
    chk("midrst_pulses", p, 0);
    chk("midrst_active", voice_active, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_wave", wave, 0);
    frame("post_mid1", 8'h5A, 8'h5A);
    frame("post_mid2", 8'h5A, 8'h5A);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
